// File: rtl/spi_pkg.sv
// Shared constants and control-word layout for the SPI register stage.
// Contents: DATA_W/ADDR_W/DEPTH constants, ctrl_t control word struct and
// field bit-position localparams.
package spi_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;

    // Field bit positions within the control word.
    localparam int unsigned CtrlSendBit     = 0;
    localparam int unsigned CtrlAllOnesBit  = 1;
    localparam int unsigned CtrlAllZerosBit = 2;
    localparam int unsigned CtrlTxEndLsb    = 4;
    localparam int unsigned CtrlTxEndMsb    = 12;
    localparam int unsigned CtrlRxEndLsb    = 16;
    localparam int unsigned CtrlRxEndMsb    = 25;
    localparam int unsigned CtrlRsvdLsb     = 26;
    localparam int unsigned CtrlRsvdMsb     = 31;

    // Packed MSB-first; the pad fields cover the unused bits 15:13 and 3.
    typedef struct packed {
        logic [5:0] rsvd;       // 31:26
        logic [9:0] n_rx_end;   // 25:16
        logic [2:0] pad1;       // 15:13
        logic [8:0] n_tx_end;   // 12:4
        logic       pad0;       // 3
        logic       all_zeros;  // 2
        logic       all_ones;   // 1
        logic       send;       // 0
    } ctrl_t;

endpackage

// File: rtl/spi_data_bank.sv
// DEPTH x DATA_W flop array for the SPI data bank.
// Ports:
//   clck_i/rst_i         clock, synchronous active-high reset (clears every entry)
//   spi_we_i/addr/data   SPI-side write port, wins over the host port on an address clash
//   host_we_i/addr/data  host-side write port
//   spi_rd_o             mem[spi_addr_i], combinational (no write bypass)
//   host_rd_o            mem[host_addr_i], registered (read-during-write gives old word)
module spi_data_bank
    import spi_pkg::*;
#(
    parameter int unsigned DataW = DATA_W,
    parameter int unsigned AddrW = ADDR_W,
    parameter int unsigned Depth = DEPTH
) (
    input  logic             clck_i,
    input  logic             rst_i,
    input  logic             spi_we_i,
    input  logic [AddrW-1:0] spi_addr_i,
    input  logic [DataW-1:0] spi_data_i,
    input  logic             host_we_i,
    input  logic [AddrW-1:0] host_addr_i,
    input  logic [DataW-1:0] host_data_i,
    output logic [DataW-1:0] spi_rd_o,
    output logic [DataW-1:0] host_rd_o
);

    logic [DataW-1:0] mem_q [Depth];
    logic [DataW-1:0] host_rd_q;

    always_ff @(posedge clck_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            host_rd_q <= '0;
        end else begin
            host_rd_q <= mem_q[host_addr_i];
            // Host first, SPI second: the later assignment wins on a clash.
            if (host_we_i) begin
                mem_q[host_addr_i] <= host_data_i;
            end
            if (spi_we_i) begin
                mem_q[spi_addr_i] <= spi_data_i;
            end
        end
    end

    assign spi_rd_o  = mem_q[spi_addr_i];
    assign host_rd_o = host_rd_q;

endmodule

// File: rtl/spi_reg_bank.sv
// Register stage upstream of the SPI master: control register, one-deep
// deferred host control write, and the data bank with host/SPI arbitration.
// Ports:
//   clck_i, rst_i                      clock, synchronous active-high reset
//   h_we_ctrl_i, h_ctrl_i              host control write
//   h_we_data_i, h_addr_i, h_data_i    host data write / read address
//   h_rd_o, h_ctrl_o, h_pend_o, h_err_o host readback, pending flag, drop pulse
//   wr1_i, in1_i                       SPI-side control write
//   wr2_i, addr2_i, in2_i              SPI-side data write / transmit read address
//   hold_ctrl_i                        SPI master owns the control register
//   inst_o, reg_o                      control word, transmit word
module spi_reg_bank
    import spi_pkg::*;
(
    input  logic              clck_i,
    input  logic              rst_i,
    input  logic              h_we_ctrl_i,
    input  logic [DATA_W-1:0] h_ctrl_i,
    input  logic              h_we_data_i,
    input  logic [ADDR_W-1:0] h_addr_i,
    input  logic [DATA_W-1:0] h_data_i,
    output logic [DATA_W-1:0] h_rd_o,
    output logic [DATA_W-1:0] h_ctrl_o,
    output logic              h_pend_o,
    output logic              h_err_o,
    input  logic              wr1_i,
    input  logic [DATA_W-1:0] in1_i,
    input  logic              wr2_i,
    input  logic [ADDR_W-1:0] addr2_i,
    input  logic [DATA_W-1:0] in2_i,
    input  logic              hold_ctrl_i,
    output logic [DATA_W-1:0] inst_o,
    output logic [DATA_W-1:0] reg_o
);

    logic [DATA_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] pend_word_q, pend_word_d;
    logic              pend_q, pend_d;
    logic              err_q, err_d;
    logic              host_data_we;
    logic              data_clash;

    always_comb begin
        ctrl_d      = ctrl_q;
        pend_word_d = pend_word_q;
        pend_d      = pend_q;

        if (wr1_i) begin
            ctrl_d = in1_i;
        end else if (!hold_ctrl_i && pend_q) begin
            ctrl_d = pend_word_q;
            pend_d = 1'b0;
        end else if (!hold_ctrl_i && h_we_ctrl_i) begin
            ctrl_d = h_ctrl_i;
        end

        // A host write that cannot land directly this cycle (register owned,
        // SPI write, or a pending word draining) becomes the pending word.
        if (h_we_ctrl_i && (hold_ctrl_i || wr1_i || pend_q)) begin
            pend_word_d = h_ctrl_i;
            pend_d      = 1'b1;
        end
    end

    assign data_clash   = wr2_i && (addr2_i == h_addr_i);
    assign host_data_we = h_we_data_i && !hold_ctrl_i && !data_clash;
    assign err_d        = h_we_data_i && (hold_ctrl_i || data_clash);

    always_ff @(posedge clck_i) begin
        if (rst_i) begin
            ctrl_q      <= '0;
            pend_word_q <= '0;
            pend_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            ctrl_q      <= ctrl_d;
            pend_word_q <= pend_word_d;
            pend_q      <= pend_d;
            err_q       <= err_d;
        end
    end

    spi_data_bank u_bank (
        .clck_i      (clck_i),
        .rst_i       (rst_i),
        .spi_we_i    (wr2_i),
        .spi_addr_i  (addr2_i),
        .spi_data_i  (in2_i),
        .host_we_i   (host_data_we),
        .host_addr_i (h_addr_i),
        .host_data_i (h_data_i),
        .spi_rd_o    (reg_o),
        .host_rd_o   (h_rd_o)
    );

    assign inst_o   = ctrl_q;
    assign h_ctrl_o = ctrl_q;
    assign h_pend_o = pend_q;
    assign h_err_o  = err_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
module tb_spi_reg_bank;
    import spi_pkg::*;

    logic              clck = 1'b0;
    logic              rst_i;
    logic              h_we_ctrl_i;
    logic [DATA_W-1:0] h_ctrl_i;
    logic              h_we_data_i;
    logic [ADDR_W-1:0] h_addr_i;
    logic [DATA_W-1:0] h_data_i;
    logic [DATA_W-1:0] h_rd_o;
    logic [DATA_W-1:0] h_ctrl_o;
    logic              h_pend_o;
    logic              h_err_o;
    logic              wr1_i;
    logic [DATA_W-1:0] in1_i;
    logic              wr2_i;
    logic [ADDR_W-1:0] addr2_i;
    logic [DATA_W-1:0] in2_i;
    logic              hold_ctrl_i;
    logic [DATA_W-1:0] inst_o;
    logic [DATA_W-1:0] reg_o;

    int checks   = 0;
    int failures = 0;
    ctrl_t cw;

    always #5 clck = ~clck;

    spi_reg_bank dut (
        .clck_i      (clck),
        .rst_i       (rst_i),
        .h_we_ctrl_i (h_we_ctrl_i),
        .h_ctrl_i    (h_ctrl_i),
        .h_we_data_i (h_we_data_i),
        .h_addr_i    (h_addr_i),
        .h_data_i    (h_data_i),
        .h_rd_o      (h_rd_o),
        .h_ctrl_o    (h_ctrl_o),
        .h_pend_o    (h_pend_o),
        .h_err_o     (h_err_o),
        .wr1_i       (wr1_i),
        .in1_i       (in1_i),
        .wr2_i       (wr2_i),
        .addr2_i     (addr2_i),
        .in2_i       (in2_i),
        .hold_ctrl_i (hold_ctrl_i),
        .inst_o      (inst_o),
        .reg_o       (reg_o)
    );

    task automatic step();
        @(posedge clck);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_i = 1'b1; h_we_ctrl_i = 0; h_ctrl_i = '0; h_we_data_i = 0; h_addr_i = '0;
        h_data_i = '0; wr1_i = 0; in1_i = '0; wr2_i = 0; addr2_i = '0; in2_i = '0;
        hold_ctrl_i = 0;
        step(); step();
        rst_i = 1'b0;
        #1;
        check("rst_inst", inst_o, 32'h0);
        check("rst_hctrl", h_ctrl_o, 32'h0);
        check("rst_reg", reg_o, 32'h0);
        check("rst_hrd", h_rd_o, 32'h0);
        check("rst_pend", {31'b0, h_pend_o}, 32'h0);
        check("rst_err", {31'b0, h_err_o}, 32'h0);

        // 1: direct host control write
        h_we_ctrl_i = 1; h_ctrl_i = 32'h0000_1031;
        step();
        h_we_ctrl_i = 0;
        check("t1_inst", inst_o, 32'h0000_1031);
        check("t1_pend", {31'b0, h_pend_o}, 32'h0);
        cw = inst_o;
        check("t1_tx_end", {23'b0, cw.n_tx_end}, 32'h103);
        check("t1_send", {31'b0, cw.send}, 32'h1);

        // 2: deferred write under hold
        hold_ctrl_i = 1; h_we_ctrl_i = 1; h_ctrl_i = 32'h0000_0001;
        step();
        h_we_ctrl_i = 0;
        check("t2_pend", {31'b0, h_pend_o}, 32'h1);
        check("t2_inst_held", inst_o, 32'h0000_1031);
        check("t2_no_err", {31'b0, h_err_o}, 32'h0);
        hold_ctrl_i = 0;
        step();
        check("t2_drain", inst_o, 32'h0000_0001);
        check("t2_pend_clr", {31'b0, h_pend_o}, 32'h0);

        // 3: SPI write wins, host word deferred
        hold_ctrl_i = 1; wr1_i = 1; in1_i = 32'h0005_0000;
        h_we_ctrl_i = 1; h_ctrl_i = 32'h0000_0002;
        step();
        wr1_i = 0; h_we_ctrl_i = 0;
        check("t3_inst", inst_o, 32'h0005_0000);
        check("t3_pend", {31'b0, h_pend_o}, 32'h1);
        hold_ctrl_i = 0;
        step();
        check("t3_drain", inst_o, 32'h0000_0002);
        check("t3_pend_clr", {31'b0, h_pend_o}, 32'h0);

        // 3b: host write during a drain replaces the pending word
        hold_ctrl_i = 1; h_we_ctrl_i = 1; h_ctrl_i = 32'h0000_0011;
        step();
        hold_ctrl_i = 0; h_ctrl_i = 32'h0000_0022;
        step();
        h_we_ctrl_i = 0;
        check("t3b_drain1", inst_o, 32'h0000_0011);
        check("t3b_pend_kept", {31'b0, h_pend_o}, 32'h1);
        step();
        check("t3b_drain2", inst_o, 32'h0000_0022);
        check("t3b_pend_clr", {31'b0, h_pend_o}, 32'h0);

        // 4: same-address data clash, SPI wins
        wr2_i = 1; addr2_i = 5'd7; in2_i = 32'hA5A5_A5A5;
        h_we_data_i = 1; h_addr_i = 5'd7; h_data_i = 32'h1234_5678;
        step();
        wr2_i = 0; h_we_data_i = 0;
        check("t4_err", {31'b0, h_err_o}, 32'h1);
        check("t4_reg", reg_o, 32'hA5A5_A5A5);
        step();
        check("t4_err_pulse", {31'b0, h_err_o}, 32'h0);
        check("t4_hrd", h_rd_o, 32'hA5A5_A5A5);

        // Host data write dropped under hold
        hold_ctrl_i = 1; h_we_data_i = 1; h_addr_i = 5'd9; h_data_i = 32'h0000_0099;
        step();
        hold_ctrl_i = 0; h_we_data_i = 0; addr2_i = 5'd9;
        #1;
        check("hold_err", {31'b0, h_err_o}, 32'h1);
        check("hold_drop", reg_o, 32'h0);

        // Different addresses: both commit
        wr2_i = 1; addr2_i = 5'd1; in2_i = 32'h0000_0111;
        h_we_data_i = 1; h_addr_i = 5'd2; h_data_i = 32'h0000_0222;
        step();
        wr2_i = 0; h_we_data_i = 0;
        check("both_err", {31'b0, h_err_o}, 32'h0);
        check("both_spi", reg_o, 32'h0000_0111);
        addr2_i = 5'd2;
        #1;
        check("both_host", reg_o, 32'h0000_0222);

        // 5: host write visible on reg_o only after the edge; h_rd_o old on RDW
        h_we_data_i = 1; h_addr_i = 5'd3; h_data_i = 32'hDEAD_BEEF; addr2_i = 5'd3;
        #1;
        check("t5_no_bypass", reg_o, 32'h0);
        step();
        h_we_data_i = 0;
        check("t5_reg", reg_o, 32'hDEAD_BEEF);
        check("t5_rdw_old", h_rd_o, 32'h0);
        step();
        check("t5_hrd", h_rd_o, 32'hDEAD_BEEF);

        // 6: reset with pending word and populated bank
        hold_ctrl_i = 1; h_we_ctrl_i = 1; h_ctrl_i = 32'h0000_0077;
        step();
        h_we_ctrl_i = 0;
        check("t6_pend_set", {31'b0, h_pend_o}, 32'h1);
        rst_i = 1;
        step();
        rst_i = 0; hold_ctrl_i = 0;
        #1;
        check("t6_inst", inst_o, 32'h0);
        check("t6_pend", {31'b0, h_pend_o}, 32'h0);
        check("t6_reg", reg_o, 32'h0);
        check("t6_hrd", h_rd_o, 32'h0);
        check("t6_err", {31'b0, h_err_o}, 32'h0);
        step();
        check("t6_no_drain", inst_o, 32'h0);
        check("t6_hrd_cleared", h_rd_o, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
